question_select_engine: RTL and testbench

Parametrised successor to the single-shot question picker in the quiz game datapath. It draws a pseudo-random question ID in the range 0 to NUM_Q-1 from a free-running LFSR, using rejection sampling. It refuses any ID held in a short no-repeat history, falls back to a deterministic scan when random draws keep failing, and looks up the correct answer in a registered ROM. It sits between the game controller, which issues `question_req`, and the display/answer-check logic, which consumes `question_ready`, `selected_q_id` and `correct_ans`.

---
 rtl/question_pkg.sv | 43 ++++
 rtl/question_select_engine_rom.sv | 35 +++
 rtl/question_select_engine.sv | 184 ++++++++++++++++++
 tb/tb_question_select_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/question_pkg.sv
// Shared definitions for the question select engine.
//   - q_state_e : controller state encoding
//   - lfsr_taps : maximal-length Fibonacci tap mask for LFSR widths 4..16
//   - ANS_TABLE : correct answer per question ID (8-bit entries, truncated at use)
package question_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDraw,
      StScan,
      StLookup,
      StDone
   } q_state_e;

   // Bit i set means register bit i feeds the XOR; feedback enters bit 0 on a left shift.
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      logic [15:0] t;
      case (width)
         4:       t = 16'h000C;
         5:       t = 16'h0014;
         6:       t = 16'h0030;
         7:       t = 16'h0060;
         8:       t = 16'h00B8;
         9:       t = 16'h0110;
         10:      t = 16'h0240;
         11:      t = 16'h0500;
         12:      t = 16'h0829;
         13:      t = 16'h100D;
         14:      t = 16'h2015;
         15:      t = 16'h6000;
         16:      t = 16'hD008;
         default: t = 16'h0000;
      endcase
      return t;
   endfunction

   localparam logic [7:0] ANS_TABLE [256] = '{
      0: 8'd3,  1: 8'd7,  2: 8'd5,  3: 8'd9,  4: 8'd15,
      5: 8'd8,  6: 8'd12, 7: 8'd7,  8: 8'd14, 9: 8'd15,
      default: 8'd0
   };

endpackage

// File: rtl/question_select_engine_rom.sv
// Registered answer ROM. ans_o updates one cycle after a read with rd_en_i high and
// otherwise holds, so it can drive the engine's correct_ans output directly.
//   clk_i, rst_ni : clock, async active-low reset (ans_o resets to ANS_TABLE[0])
//   rd_en_i       : read strobe
//   addr_i        : question ID
//   ans_o         : registered answer
module question_answer_rom
   import question_pkg::*;
#(
   parameter int unsigned NUM_Q = 10,
   parameter int unsigned ANS_W = 4,
   localparam int unsigned QID_W = $clog2(NUM_Q)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             rd_en_i,
   input  logic [QID_W-1:0] addr_i,
   output logic [ANS_W-1:0] ans_o
);

   logic [ANS_W-1:0] ans_d, ans_q;

   always_comb begin
      ans_d = ans_q;
      if (rd_en_i) ans_d = ANS_W'(ANS_TABLE[8'(addr_i)]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ans_q <= ANS_W'(ANS_TABLE[0]);
      else         ans_q <= ans_d;
   end

   assign ans_o = ans_q;

endmodule

// File: rtl/question_select_engine.sv
// Picks a pseudo-random question ID in 0..NUM_Q-1 by rejection sampling on a
// free-running LFSR, avoiding the last HIST_DEPTH IDs, with a deterministic scan
// fallback after MAX_TRIES failed draws; then looks up the answer.
//   clk_100mhz, reset_n        : clock, async active-low reset
//   question_req               : start a selection (IDLE only)
//   seed_load, seed_val        : reseed LFSR (zero value selects SEED)
//   history_clear              : empty the no-repeat history
//   busy, question_ready       : status, one-cycle result strobe
//   selected_q_id, correct_ans : result, held until the next result
//   fallback_used              : result came from the scan
module question_select_engine
   import question_pkg::*;
#(
   parameter int unsigned NUM_Q      = 10,
   parameter int unsigned LFSR_W     = 8,
   parameter int unsigned ANS_W      = 4,
   parameter int unsigned HIST_DEPTH = 4,
   parameter int unsigned MAX_TRIES  = 16,
   parameter logic [LFSR_W-1:0] SEED = LFSR_W'(8'hB5),
   localparam int unsigned QID_W     = $clog2(NUM_Q)
) (
   input  logic              clk_100mhz,
   input  logic              reset_n,
   input  logic              question_req,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_val,
   input  logic              history_clear,
   output logic              busy,
   output logic              question_ready,
   output logic [QID_W-1:0]  selected_q_id,
   output logic [ANS_W-1:0]  correct_ans,
   output logic              fallback_used
);

   // Keep one storage slot when history is disabled; hits are masked off instead.
   localparam int unsigned HD    = (HIST_DEPTH == 0) ? 1 : HIST_DEPTH;
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

   q_state_e                   state_d, state_q;
   logic [LFSR_W-1:0]          lfsr_d, lfsr_q;
   logic [TRY_W-1:0]           tries_d, tries_q;
   logic [QID_W-1:0]           scan_ptr_d, scan_ptr_q;
   logic [QID_W-1:0]           cur_id_d, cur_id_q;
   logic                       cur_fb_d, cur_fb_q;
   logic [QID_W-1:0]           sel_id_d, sel_id_q;
   logic                       fb_d, fb_q;
   logic [QID_W-1:0]           last_id_d, last_id_q;
   logic [HD-1:0][QID_W-1:0]   hist_id_d, hist_id_q;
   logic [HD-1:0]              hist_vld_d, hist_vld_q;

   logic [QID_W-1:0] cand;
   logic             cand_hit, scan_hit;

   function automatic logic [QID_W-1:0] next_id(input logic [QID_W-1:0] id);
      if (32'(id) == NUM_Q - 1) return '0;
      else                      return id + 1'b1;
   endfunction

   assign cand = lfsr_q[QID_W-1:0];

   always_comb begin
      cand_hit = 1'b0;
      scan_hit = 1'b0;
      for (int unsigned i = 0; i < HD; i++) begin
         if (HIST_DEPTH != 0 && hist_vld_q[i]) begin
            if (hist_id_q[i] == cand)       cand_hit = 1'b1;
            if (hist_id_q[i] == scan_ptr_q) scan_hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      scan_ptr_d = scan_ptr_q;
      cur_id_d   = cur_id_q;
      cur_fb_d   = cur_fb_q;
      sel_id_d   = sel_id_q;
      fb_d       = fb_q;
      last_id_d  = last_id_q;
      hist_id_d  = hist_id_q;
      hist_vld_d = hist_vld_q;

      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
      if (seed_load) lfsr_d = (seed_val == '0) ? SEED : seed_val;

      case (state_q)
         StIdle: begin
            if (question_req) begin
               tries_d = '0;
               state_d = StDraw;
            end
         end
         StDraw: begin
            if (32'(cand) < NUM_Q && !cand_hit) begin
               cur_id_d = cand;
               cur_fb_d = 1'b0;
               state_d  = StLookup;
            end else begin
               tries_d = tries_q + 1'b1;
               if (32'(tries_q) + 32'd1 == MAX_TRIES) begin
                  scan_ptr_d = next_id(last_id_q);
                  state_d    = StScan;
               end
            end
         end
         StScan: begin
            if (!scan_hit) begin
               cur_id_d = scan_ptr_q;
               cur_fb_d = 1'b1;
               state_d  = StLookup;
            end else begin
               scan_ptr_d = next_id(scan_ptr_q);
            end
         end
         StLookup: begin
            // ROM read happens on this edge too, so all result outputs change together.
            sel_id_d = cur_id_q;
            fb_d     = cur_fb_q;
            state_d  = StDone;
         end
         StDone: begin
            for (int unsigned i = 1; i < HD; i++) begin
               hist_id_d[i]  = hist_id_q[i-1];
               hist_vld_d[i] = hist_vld_q[i-1];
            end
            hist_id_d[0]  = cur_id_q;
            hist_vld_d[0] = 1'b1;
            last_id_d     = cur_id_q;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Clear has priority over a simultaneous push.
      if (history_clear) hist_vld_d = '0;
   end

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         lfsr_q     <= SEED;
         tries_q    <= '0;
         scan_ptr_q <= '0;
         cur_id_q   <= '0;
         cur_fb_q   <= 1'b0;
         sel_id_q   <= '0;
         fb_q       <= 1'b0;
         last_id_q  <= QID_W'(NUM_Q - 1);
         hist_id_q  <= '0;
         hist_vld_q <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         tries_q    <= tries_d;
         scan_ptr_q <= scan_ptr_d;
         cur_id_q   <= cur_id_d;
         cur_fb_q   <= cur_fb_d;
         sel_id_q   <= sel_id_d;
         fb_q       <= fb_d;
         last_id_q  <= last_id_d;
         hist_id_q  <= hist_id_d;
         hist_vld_q <= hist_vld_d;
      end
   end

   question_answer_rom #(
      .NUM_Q (NUM_Q),
      .ANS_W (ANS_W)
   ) u_rom (
      .clk_i   (clk_100mhz),
      .rst_ni  (reset_n),
      .rd_en_i (state_q == StLookup),
      .addr_i  (cur_id_q),
      .ans_o   (correct_ans)
   );

   assign busy           = (state_q != StIdle);
   assign question_ready = (state_q == StDone);
   assign selected_q_id  = sel_id_q;
   assign fallback_used  = fb_q;

endmodule

// File: tb/tb_question_select_engine.sv
// Bench for question_select_engine. dut_a uses default parameters, dut_b uses
// MAX_TRIES=1 so that one rejected draw forces the scan. Both share inputs.
module tb_question_select_engine;

   typedef struct {
      int id;
      int ans;
      int fb;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       question_req = 1'b0;
   logic       seed_load = 1'b0;
   logic [7:0] seed_val = 8'h00;
   logic       history_clear = 1'b0;

   logic       busy_a, ready_a, fb_a;
   logic [3:0] id_a, ans_a;
   logic       busy_b, ready_b, fb_b;
   logic [3:0] id_b, ans_b;

   int n_vec = 0;
   int n_err = 0;
   int cnt_a = 0;
   int cnt_b = 0;

   int         ans_tab [10] = '{3, 7, 5, 9, 15, 8, 12, 7, 14, 15};
   logic [7:0] m_lfsr;
   int         m_hist[$];
   int         m_last = 9;
   exp_t       exp_q[$];

   always #5 clk = ~clk;

   question_select_engine #(
      .NUM_Q(10), .LFSR_W(8), .ANS_W(4), .HIST_DEPTH(4), .MAX_TRIES(16), .SEED(8'hB5)
   ) dut_a (
      .clk_100mhz(clk), .reset_n(reset_n), .question_req(question_req),
      .seed_load(seed_load), .seed_val(seed_val), .history_clear(history_clear),
      .busy(busy_a), .question_ready(ready_a), .selected_q_id(id_a),
      .correct_ans(ans_a), .fallback_used(fb_a)
   );

   question_select_engine #(
      .NUM_Q(10), .LFSR_W(8), .ANS_W(4), .HIST_DEPTH(4), .MAX_TRIES(1), .SEED(8'hB5)
   ) dut_b (
      .clk_100mhz(clk), .reset_n(reset_n), .question_req(question_req),
      .seed_load(seed_load), .seed_val(seed_val), .history_clear(history_clear),
      .busy(busy_b), .question_ready(ready_b), .selected_q_id(id_b),
      .correct_ans(ans_b), .fallback_used(fb_b)
   );

   // x^8+x^6+x^5+x^4+1, shifted left, feedback into bit 0.
   function automatic logic [7:0] step8(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)       m_lfsr <= 8'hB5;
      else if (seed_load) m_lfsr <= (seed_val == 8'h00) ? 8'hB5 : seed_val;
      else                m_lfsr <= step8(m_lfsr);
   end

   always @(posedge clk) begin
      if (ready_a) cnt_a <= cnt_a + 1;
      if (ready_b) cnt_b <= cnt_b + 1;
   end

   function automatic bit in_hist(input int v);
      foreach (m_hist[i]) if (m_hist[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   // First seed whose next LFSR value gives candidate `want`, or an out-of-range one.
   function automatic logic [7:0] find_seed(input int want, input bit invalid);
      logic [7:0] n;
      for (int s = 1; s < 256; s++) begin
         n = step8(8'(s));
         if (invalid ? (n[3:0] >= 4'd10) : (int'(n[3:0]) == want)) return 8'(s);
      end
      return 8'h01;
   endfunction

   // Predict the result of a request sampled at the coming edge and update the model.
   task automatic predict_push(input int mt);
      logic [7:0] l;
      int id, fb, cyc;
      bit found;
      l = m_lfsr; found = 0; id = 0; cyc = 0;
      for (int i = 0; i < mt; i++) begin
         l = step8(l);
         if (!found && l[3:0] < 4'd10 && !in_hist(int'(l[3:0]))) begin
            found = 1; id = int'(l[3:0]); cyc = 3 + i;
         end
      end
      fb = found ? 0 : 1;
      if (!found) begin
         id = (m_last + 1) % 10;
         cyc = 3 + mt;
         while (in_hist(id)) begin
            id = (id + 1) % 10;
            cyc++;
         end
      end
      exp_q.push_back('{id, ans_tab[id], fb, cyc});
      m_hist.push_front(id);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      m_last = id;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; question_req = 1'b0; seed_load = 1'b0; seed_val = 8'h00;
      history_clear = 1'b0;
      m_hist.delete(); m_last = 9; exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_seed(input logic [7:0] s);
      seed_load = 1'b1; seed_val = s;
      @(negedge clk);
      seed_load = 1'b0;
   endtask

   task automatic issue_req(input int mt);
      question_req = 1'b1;
      predict_push(mt);
      @(negedge clk);
      question_req = 1'b0;
   endtask

   // Returns at the negedge where question_ready is seen; cyc is the cycle index after req.
   task automatic wait_ready(input bit sel_b, output bit to, output int id, output int ans,
                             output int fb, output int cyc);
      to = 1'b1; id = 0; ans = 0; fb = 0; cyc = 0;
      for (int k = 0; k < 60; k++) begin
         if ((sel_b ? ready_b : ready_a) === 1'b1) begin
            id  = sel_b ? int'(id_b) : int'(id_a);
            ans = sel_b ? int'(ans_b) : int'(ans_a);
            fb  = sel_b ? int'(fb_b) : int'(fb_a);
            cyc = k + 1;
            to  = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_vec += 6;
      if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_a); end
      if (ready_a !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready_a); end
      if (fb_a !== 1'b0) begin n_err++; $display("FAIL reset_fb got %b want 0", fb_a); end
      if (id_a !== 4'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", id_a); end
      if (ans_a !== 4'd3) begin n_err++; $display("FAIL reset_ans got %0d want 3", ans_a); end
      if (ans_b !== 4'd3) begin n_err++; $display("FAIL reset_ans_b got %0d want 3", ans_b); end
   endtask

   task automatic test_seed_zero();
      exp_t e; bit to; int id, ans, fb, cyc;
      load_seed(8'h00);
      issue_req(16);
      wait_ready(1'b0, to, id, ans, fb, cyc);
      e = exp_q.pop_front();
      n_vec++;
      if (to || id != e.id || ans != e.ans || fb != e.fb || cyc != e.cyc) begin
         n_err++;
         $display("FAIL seed_zero got to=%0d id=%0d ans=%0d fb=%0d cyc=%0d want id=%0d ans=%0d fb=%0d cyc=%0d",
                  to, id, ans, fb, cyc, e.id, e.ans, e.fb, e.cyc);
      end
      @(negedge clk);
      n_vec += 2;
      if (ready_a !== 1'b0) begin n_err++; $display("FAIL ready_width got %b want 0", ready_a); end
      if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_fall got %b want 0", busy_a); end
   endtask

   task automatic test_no_repeat();
      exp_t e; bit to; int id, ans, fb, cyc;
      int recent[$];
      for (int n = 0; n < 200; n++) begin
         issue_req(16);
         wait_ready(1'b0, to, id, ans, fb, cyc);
         e = exp_q.pop_front();
         n_vec += 2;
         if (to || id != e.id || ans != e.ans || fb != e.fb || cyc != e.cyc) begin
            n_err++;
            $display("FAIL draw_%0d got to=%0d id=%0d ans=%0d fb=%0d cyc=%0d want id=%0d ans=%0d fb=%0d cyc=%0d",
                     n, to, id, ans, fb, cyc, e.id, e.ans, e.fb, e.cyc);
         end
         if (id >= 10 || (id inside {recent})) begin
            n_err++;
            $display("FAIL window_%0d got id=%0d want <10 and not in last 4", n, id);
         end
         recent.push_front(id);
         if (recent.size() > 4) void'(recent.pop_back());
         @(negedge clk);
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e; bit to; int id, ans, fb, cyc, c0;
      c0 = cnt_a;
      issue_req(16);
      n_vec++;
      if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_rise got %b want 1", busy_a); end
      question_req = 1'b1;  // held through the busy window; must be dropped
      wait_ready(1'b0, to, id, ans, fb, cyc);
      question_req = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (to || id != e.id || ans != e.ans || fb != e.fb || cyc != e.cyc) begin
         n_err++;
         $display("FAIL busy_req got to=%0d id=%0d ans=%0d fb=%0d cyc=%0d want id=%0d ans=%0d fb=%0d cyc=%0d",
                  to, id, ans, fb, cyc, e.id, e.ans, e.fb, e.cyc);
      end
      repeat (8) @(negedge clk);
      n_vec += 2;
      if (cnt_a - c0 != 1) begin n_err++; $display("FAIL ready_count got %0d want 1", cnt_a - c0); end
      if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_idle got %b want 0", busy_a); end
   endtask

   task automatic test_fallback();
      exp_t e; bit to; int id, ans, fb, cyc;
      int pick [4] = '{-1, 1, 0, -1};
      do_reset();
      for (int r = 0; r < 4; r++) begin
         if (r == 1) do_reset();
         load_seed(find_seed(pick[r] < 0 ? 0 : pick[r], pick[r] < 0));
         issue_req(1);
         wait_ready(1'b1, to, id, ans, fb, cyc);
         e = exp_q.pop_front();
         n_vec++;
         if (to || id != e.id || ans != e.ans || fb != e.fb || cyc != e.cyc) begin
            n_err++;
            $display("FAIL fallback_%0d got to=%0d id=%0d ans=%0d fb=%0d cyc=%0d want id=%0d ans=%0d fb=%0d cyc=%0d",
                     r, to, id, ans, fb, cyc, e.id, e.ans, e.fb, e.cyc);
         end
         if (r == 0) begin
            n_vec++;
            if (id != 0 || fb != 1 || ans != 3) begin
               n_err++;
               $display("FAIL fallback_first got id=%0d fb=%0d ans=%0d want 0 1 3", id, fb, ans);
            end
         end
         if (r == 3) begin
            n_vec++;
            if (id != 2 || fb != 1 || ans != 5) begin
               n_err++;
               $display("FAIL fallback_skip got id=%0d fb=%0d ans=%0d want 2 1 5", id, fb, ans);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_history_clear();
      exp_t e; bit to; int id, ans, fb, cyc;
      logic [7:0] s;
      do_reset();
      s = find_seed(5, 1'b0);
      for (int r = 0; r < 2; r++) begin
         load_seed(s);
         issue_req(16);
         wait_ready(1'b0, to, id, ans, fb, cyc);
         e = exp_q.pop_front();
         n_vec += 2;
         if (to || id != e.id || ans != e.ans || fb != e.fb || cyc != e.cyc) begin
            n_err++;
            $display("FAIL hclear_%0d got to=%0d id=%0d ans=%0d fb=%0d cyc=%0d want id=%0d ans=%0d fb=%0d cyc=%0d",
                     r, to, id, ans, fb, cyc, e.id, e.ans, e.fb, e.cyc);
         end
         if (id != 5 || fb != 0 || cyc != 3) begin
            n_err++;
            $display("FAIL hclear_repeat_%0d got id=%0d fb=%0d cyc=%0d want 5 0 3", r, id, fb, cyc);
         end
         history_clear = 1'b1;  // coincides with the DONE push
         @(negedge clk);
         history_clear = 1'b0;
         m_hist.delete();
      end
   endtask

   task automatic test_reset_in_scan();
      exp_t e; bit to; int id, ans, fb, cyc, c0;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         load_seed(find_seed(0, 1'b1));
         issue_req(1);
         wait_ready(1'b1, to, id, ans, fb, cyc);
         e = exp_q.pop_front();
         n_vec++;
         if (to || id != e.id || ans != e.ans || fb != e.fb || cyc != e.cyc) begin
            n_err++;
            $display("FAIL prescan_%0d got to=%0d id=%0d ans=%0d fb=%0d cyc=%0d want id=%0d ans=%0d fb=%0d cyc=%0d",
                     r, to, id, ans, fb, cyc, e.id, e.ans, e.fb, e.cyc);
         end
         @(negedge clk);
      end
      load_seed(find_seed(0, 1'b1));
      issue_req(1);
      @(negedge clk);  // cycle 2: scanning
      n_vec++;
      if (busy_b !== 1'b1) begin n_err++; $display("FAIL scan_busy got %b want 1", busy_b); end
      c0 = cnt_b;
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (busy_b !== 1'b0 || ready_b !== 1'b0 || id_b !== 4'd0 || ans_b !== 4'd3 || fb_b !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset got busy=%b rdy=%b id=%0d ans=%0d fb=%b want 0 0 0 3 0",
                  busy_b, ready_b, id_b, ans_b, fb_b);
      end
      exp_q.delete(); m_hist.delete(); m_last = 9;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      n_vec++;
      if (cnt_b != c0) begin n_err++; $display("FAIL aborted_ready got %0d want 0", cnt_b - c0); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_seed_zero();
      test_no_repeat();
      test_busy_ignore();
      test_fallback();
      test_history_clear();
      test_reset_in_scan();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
